// File: rtl/mipi_dphy_pkg.sv
// Shared definitions for the MIPI D-PHY HS receive front end.
// Contents: lane FSM state codes, LP line-state codes ({Dp,Dn}) and the HS sync byte.
package mipi_dphy_pkg;

   // Lane FSM state encoding; the raw codes are also exported on lane_state for debug.
   typedef logic [2:0] lane_state_t;

   localparam lane_state_t StStop = 3'd0;
   localparam lane_state_t StRqst = 3'd1;
   localparam lane_state_t StPrep = 3'd2;
   localparam lane_state_t StData = 3'd3;
   localparam lane_state_t StErr  = 3'd4;

   // LP line states as {Dp,Dn}.
   localparam logic [1:0] LP11 = 2'b11;
   localparam logic [1:0] LP01 = 2'b01;
   localparam logic [1:0] LP00 = 2'b00;
   localparam logic [1:0] LP10 = 2'b10;

   localparam logic [7:0] HS_SYNC_BYTE = 8'hB8;

endpackage

// File: rtl/mipi_dphy_lane_rx.sv
// Single D-PHY data lane receiver: LP entry FSM, HS sync hunter and LSB-first byte assembler.
// Ports:
//   sys_clk, sys_rst  HS bit clock, synchronous active-high reset
//   lp                LP line state {Dp,Dn}
//   hs_bit            resolved HS bit, one per clock
//   byte_data         last assembled byte (valid with byte_strobe)
//   byte_strobe       one-cycle pulse, byte_data holds a new byte
//   state             lane FSM state
//   sync_err          one-cycle pulse, sync hunt timed out
module mipi_dphy_lane_rx
   import mipi_dphy_pkg::*;
#(
   parameter int unsigned SYNC_TIMEOUT = 64
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [1:0]  lp,
   input  logic        hs_bit,
   output logic [7:0]  byte_data,
   output logic        byte_strobe,
   output lane_state_t state,
   output logic        sync_err
);

   lane_state_t state_q, state_d;
   logic [7:0]  sr_q, sr_d, sr_shift;
   logic [7:0]  cnt_q, cnt_d, cnt_inc;
   logic [7:0]  byte_q, byte_d;
   logic        strobe_q, strobe_d;
   logic        serr_q, serr_d;

   always_comb begin
      sr_shift = {hs_bit, sr_q[7:1]};
      cnt_inc  = cnt_q + 8'd1;
      state_d  = state_q;
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      byte_d   = byte_q;
      strobe_d = 1'b0;
      serr_d   = 1'b0;

      // LP-11 overrides everything, including a byte that would complete on this edge.
      if (lp == LP11) begin
         state_d = StStop;
         sr_d    = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            StStop: begin
               if (lp == LP01) state_d = StRqst;
            end
            StRqst: begin
               if (lp == LP00) begin
                  state_d = StPrep;
                  sr_d    = '0;
                  cnt_d   = '0;
               end else if (lp == LP10) begin
                  state_d = StStop;
               end
            end
            StPrep: begin
               sr_d  = sr_shift;
               cnt_d = cnt_inc;
               if (sr_shift == HS_SYNC_BYTE) begin
                  state_d = StData;
                  cnt_d   = '0;
               end else if (cnt_inc == 8'(SYNC_TIMEOUT)) begin
                  state_d = StErr;
                  serr_d  = 1'b1;
               end
            end
            StData: begin
               sr_d = sr_shift;
               // cnt counts bits within the current byte here.
               if (cnt_q == 8'd7) begin
                  byte_d   = sr_shift;
                  strobe_d = 1'b1;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            StErr: begin
               state_d = StErr;
            end
            default: begin
               state_d = StStop;
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q  <= StStop;
         sr_q     <= '0;
         cnt_q    <= '0;
         byte_q   <= '0;
         strobe_q <= 1'b0;
         serr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         cnt_q    <= cnt_d;
         byte_q   <= byte_d;
         strobe_q <= strobe_d;
         serr_q   <= serr_d;
      end
   end

   assign byte_data   = byte_q;
   assign byte_strobe = strobe_q;
   assign state       = state_q;
   assign sync_err    = serr_q;

endmodule

// File: rtl/mipi_dphy_hs_rx.sv
// Multi-lane MIPI D-PHY HS receive front end: per-lane receivers, per-lane deskew FIFOs and
// the merge/framing logic producing one LANES-byte word per beat.
// Ports:
//   sys_clk, sys_rst  HS bit clock, synchronous active-high reset
//   lp_data           LP line state per lane, lane k at [2k+1:2k]
//   hs_bit            HS bit per lane
//   out_data          merged word, lane k byte at [8k+7:8k]; holds when out_valid is low
//   out_valid         one-cycle strobe for out_data
//   pkt_start         pulse, first lane locked sync in this burst
//   pkt_end           pulse, burst finished; FIFOs flushed on the same edge
//   sync_err          pulse, some lane timed out hunting sync
//   skew_err          sticky lane FIFO overflow, cleared at the next pkt_start
//   lane_state        per-lane FSM state, lane k at [3k+2:3k]
module mipi_dphy_hs_rx
   import mipi_dphy_pkg::*;
#(
   parameter int unsigned LANES        = 1,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned SYNC_TIMEOUT = 64
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic [2*LANES-1:0]   lp_data,
   input  logic [LANES-1:0]     hs_bit,
   output logic [8*LANES-1:0]   out_data,
   output logic                 out_valid,
   output logic                 pkt_start,
   output logic                 pkt_end,
   output logic                 sync_err,
   output logic                 skew_err,
   output logic [3*LANES-1:0]   lane_state
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [7:0]       lane_byte   [LANES];
   lane_state_t      lane_st     [LANES];
   logic [LANES-1:0] lane_strobe;
   logic [LANES-1:0] lane_serr;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      mipi_dphy_lane_rx #(
         .SYNC_TIMEOUT(SYNC_TIMEOUT)
      ) u_lane_rx (
         .sys_clk    (sys_clk),
         .sys_rst    (sys_rst),
         .lp         (lp_data[2*k +: 2]),
         .hs_bit     (hs_bit[k]),
         .byte_data  (lane_byte[k]),
         .byte_strobe(lane_strobe[k]),
         .state      (lane_st[k]),
         .sync_err   (lane_serr[k])
      );
      assign lane_state[3*k +: 3] = lane_st[k];
   end

   // Per-lane circular deskew FIFOs.
   logic [7:0]    mem_q    [LANES][FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q [LANES];
   logic [PW-1:0] rd_ptr_q [LANES];
   logic [CW-1:0] cnt_q    [LANES];

   logic [LANES-1:0]   fifo_empty, fifo_full, lane_idle, lane_data, wr_ok, ovf;
   logic               pop, any_data, end_cond;
   logic [8*LANES-1:0] pop_word;

   logic               any_data_q, burst_q, pkt_end_q, skew_err_q, out_valid_q;
   logic [8*LANES-1:0] out_data_q;

   always_comb begin
      for (int k = 0; k < int'(LANES); k++) begin
         fifo_empty[k]      = (cnt_q[k] == '0);
         fifo_full[k]       = (cnt_q[k] == CW'(FIFO_DEPTH));
         lane_idle[k]       = (lane_st[k] == StStop) || (lane_st[k] == StErr);
         lane_data[k]       = (lane_st[k] == StData);
         pop_word[8*k +: 8] = mem_q[k][rd_ptr_q[k]];
      end
      pop      = ~|fifo_empty;
      any_data = |lane_data;
      end_cond = burst_q & (&lane_idle) & (|fifo_empty);
      // A same-cycle pop frees the slot, so a write into a full FIFO is still accepted.
      wr_ok    = lane_strobe & (~fifo_full | {LANES{pop}});
      ovf      = lane_strobe & fifo_full & ~{LANES{pop}};
   end

   assign pkt_start = any_data & ~any_data_q;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         any_data_q  <= 1'b0;
         burst_q     <= 1'b0;
         pkt_end_q   <= 1'b0;
         skew_err_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         for (int k = 0; k < int'(LANES); k++) begin
            wr_ptr_q[k] <= '0;
            rd_ptr_q[k] <= '0;
            cnt_q[k]    <= '0;
         end
      end else begin
         any_data_q  <= any_data;
         burst_q     <= (burst_q | any_data) & ~end_cond;
         pkt_end_q   <= end_cond;
         skew_err_q  <= (skew_err_q & ~pkt_start) | (|ovf);
         out_valid_q <= pop;
         if (pop) out_data_q <= pop_word;
         for (int k = 0; k < int'(LANES); k++) begin
            if (end_cond) begin
               // Leftover bytes from an unmatched lane are discarded with the burst.
               wr_ptr_q[k] <= '0;
               rd_ptr_q[k] <= '0;
               cnt_q[k]    <= '0;
            end else begin
               if (wr_ok[k]) begin
                  mem_q[k][wr_ptr_q[k]] <= lane_byte[k];
                  wr_ptr_q[k]           <= wr_ptr_q[k] + PW'(1);
               end
               if (pop) rd_ptr_q[k] <= rd_ptr_q[k] + PW'(1);
               cnt_q[k] <= cnt_q[k] + CW'(wr_ok[k]) - CW'(pop);
            end
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign pkt_end   = pkt_end_q;
   assign sync_err  = |lane_serr;
   assign skew_err  = skew_err_q;

endmodule

// File: tb/tb_mipi_dphy_hs_rx.sv
// Scoreboard bench for mipi_dphy_hs_rx: a single-lane and a two-lane instance share the clock
// and reset. Stimulus steps are queued per lane; marked steps push the expected word and its
// arrival cycle into a scoreboard queue, and a monitor pops and compares on every out_valid.
module tb_mipi_dphy_hs_rx;
   import mipi_dphy_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]  lp1;
   logic [0:0]  hs1;
   logic [7:0]  od1;
   logic        ov1, ps1, pe1, se1, ke1;
   logic [2:0]  ls1;

   logic [3:0]  lp2;
   logic [1:0]  hs2;
   logic [15:0] od2;
   logic        ov2, ps2, pe2, se2, ke2;
   logic [5:0]  ls2;

   mipi_dphy_hs_rx #(.LANES(1), .FIFO_DEPTH(4), .SYNC_TIMEOUT(64)) u_dut1 (
      .sys_clk(clk), .sys_rst(rst), .lp_data(lp1), .hs_bit(hs1), .out_data(od1),
      .out_valid(ov1), .pkt_start(ps1), .pkt_end(pe1), .sync_err(se1), .skew_err(ke1),
      .lane_state(ls1)
   );

   mipi_dphy_hs_rx #(.LANES(2), .FIFO_DEPTH(4), .SYNC_TIMEOUT(64)) u_dut2 (
      .sys_clk(clk), .sys_rst(rst), .lp_data(lp2), .hs_bit(hs2), .out_data(od2),
      .out_valid(ov2), .pkt_start(ps2), .pkt_end(pe2), .sync_err(se2), .skew_err(ke2),
      .lane_state(ls2)
   );

   // mark: 0 none, 1 push expected word, 2 record cycle of this step
   typedef struct {
      logic [1:0]  lp;
      logic        hs;
      int          mark;
      logic [15:0] exp;
   } step_t;

   typedef struct {
      logic [15:0] d;
      int          cyc;
   } exp_t;

   step_t seq[3][$];  // 0: dut1 lane, 1: dut2 lane0, 2: dut2 lane1
   exp_t  exp1[$];
   exp_t  exp2[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int tag_cyc = 0;
   int se1_cyc = -1;
   int n_ps1 = 0, n_pe1 = 0, n_se1 = 0, n_ov1 = 0;
   int n_ps2 = 0, n_pe2 = 0, n_ov2 = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Monitor / scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (ov1) begin
            n_ov1++;
            if (exp1.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL dut1_word: got %0h, required no word", od1);
            end else begin
               e = exp1.pop_front();
               check("dut1_word", 32'(od1), 32'(e.d));
               check("dut1_word_cycle", cyc, e.cyc);
            end
         end
         if (ov2) begin
            n_ov2++;
            if (exp2.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL dut2_word: got %0h, required no word", od2);
            end else begin
               e = exp2.pop_front();
               check("dut2_word", 32'(od2), 32'(e.d));
               check("dut2_word_cycle", cyc, e.cyc);
            end
         end
         if (ps1) n_ps1++;
         if (pe1) n_pe1++;
         if (se1) begin
            n_se1++;
            se1_cyc = cyc;
         end
         if (ps2) n_ps2++;
         if (pe2) n_pe2++;
      end
   end

   task automatic push_lp(input int l, input logic [1:0] lp, input int n);
      for (int i = 0; i < n; i++) seq[l].push_back('{lp, 1'b0, 0, 16'h0});
   endtask

   task automatic push_bits(input int l, input logic [7:0] b, input int n, input int mark,
                            input logic [15:0] exp);
      for (int i = 0; i < n; i++) seq[l].push_back('{LP00, b[i], (i == n - 1) ? mark : 0, exp});
   endtask

   task automatic preamble(input int l, input int delay);
      push_lp(l, LP11, 2 + delay);
      push_lp(l, LP01, 1);
      push_lp(l, LP00, 1);
      push_bits(l, HS_SYNC_BYTE, 8, 0, 16'h0);
   endtask

   task automatic play();
      step_t s[3];
      while (seq[0].size() > 0 || seq[1].size() > 0 || seq[2].size() > 0) begin
         @(negedge clk);
         for (int l = 0; l < 3; l++) begin
            if (seq[l].size() > 0) s[l] = seq[l].pop_front();
            else s[l] = '{LP11, 1'b0, 0, 16'h0};
            if (s[l].mark == 1) begin
               if (l == 0) exp1.push_back('{s[l].exp, cyc + 3});
               else exp2.push_back('{s[l].exp, cyc + 3});
            end else if (s[l].mark == 2) begin
               tag_cyc = cyc;
            end
         end
         lp1 = s[0].lp;
         hs1 = s[0].hs;
         lp2 = {s[2].lp, s[1].lp};
         hs2 = {s[2].hs, s[1].hs};
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         lp1 = LP11;
         hs1 = '0;
         lp2 = {LP11, LP11};
         hs2 = '0;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_od1"}, 32'(od1), 32'h0);
      check({tag, "_ov1"}, 32'(ov1), 32'h0);
      check({tag, "_ls1"}, 32'(ls1), 32'h0);
      check({tag, "_flags1"}, 32'({ps1, pe1, se1, ke1}), 32'h0);
      check({tag, "_od2"}, 32'(od2), 32'h0);
      check({tag, "_ov2"}, 32'(ov2), 32'h0);
      check({tag, "_ls2"}, 32'(ls2), 32'h0);
      check({tag, "_flags2"}, 32'({ps2, pe2, se2, ke2}), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] t1[8];
      int b_ps, b_pe, b_se, b_ov;
      t1[0] = 8'h00; t1[1] = 8'hFF; t1[2] = 8'h00; t1[3] = 8'h12;
      t1[4] = 8'h34; t1[5] = 8'h56; t1[6] = 8'h78; t1[7] = 8'h90;

      lp1 = LP11; hs1 = '0; lp2 = {LP11, LP11}; hs2 = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      idle(3);

      // Single lane: eight data bytes after sync.
      b_ps = n_ps1; b_pe = n_pe1;
      preamble(0, 0);
      for (int i = 0; i < 8; i++) push_bits(0, t1[i], 8, 1, {8'h00, t1[i]});
      play();
      idle(20);
      check("single_pkt_start", n_ps1 - b_ps, 1);
      check("single_pkt_end", n_pe1 - b_pe, 1);
      check("single_drained", exp1.size(), 0);

      // Sync timeout: 80 zero bits in LP-00.
      b_ps = n_ps1; b_pe = n_pe1; b_se = n_se1; b_ov = n_ov1;
      push_lp(0, LP11, 2);
      push_lp(0, LP01, 1);
      push_lp(0, LP00, 1);
      for (int i = 0; i < 80; i++) seq[0].push_back('{LP00, 1'b0, (i == 63) ? 2 : 0, 16'h0});
      play();
      @(posedge clk);
      #1;
      check("timeout_state_err", 32'(ls1), 32'(StErr));
      check("timeout_sync_err", n_se1 - b_se, 1);
      check("timeout_sync_err_cycle", se1_cyc, tag_cyc + 1);
      idle(5);
      check("timeout_state_stop", 32'(ls1), 32'(StStop));
      check("timeout_no_word", n_ov1 - b_ov, 0);
      check("timeout_no_start", n_ps1 - b_ps, 0);
      check("timeout_no_end", n_pe1 - b_pe, 0);

      // Early stop: one byte then a partial byte cut by LP-11.
      b_ps = n_ps1; b_pe = n_pe1; b_ov = n_ov1;
      preamble(0, 0);
      push_bits(0, 8'h12, 8, 1, 16'h0012);
      push_bits(0, 8'h15, 5, 0, 16'h0);
      play();
      idle(20);
      check("early_words", n_ov1 - b_ov, 1);
      check("early_pkt_end", n_pe1 - b_pe, 1);
      check("early_pkt_start", n_ps1 - b_ps, 1);

      // Overflow: lane1 locks 48 bits late; lane0 bytes C4..C6 are dropped.
      b_ps = n_ps2; b_pe = n_pe2;
      preamble(1, 0);
      for (int i = 0; i < 8; i++) push_bits(1, 8'hC0 + 8'(i), 8, 0, 16'h0);
      preamble(2, 48);
      for (int i = 0; i < 4; i++)
         push_bits(2, 8'hD0 + 8'(i), 8, 1, {8'hD0 + 8'(i), 8'hC0 + 8'(i)});
      play();
      idle(20);
      check("ovf_skew_err", 32'(ke2), 32'h1);
      check("ovf_pkt_end", n_pe2 - b_pe, 1);
      check("ovf_pkt_start", n_ps2 - b_ps, 1);
      check("ovf_drained", exp2.size(), 0);
      idle(10);
      check("ovf_skew_err_held", 32'(ke2), 32'h1);

      // Two-lane skew of 3 bits; pkt_start of this burst clears skew_err.
      b_ps = n_ps2; b_pe = n_pe2;
      preamble(1, 0);
      push_bits(1, 8'hA0, 8, 0, 16'h0);
      push_bits(1, 8'hA2, 8, 0, 16'h0);
      preamble(2, 3);
      push_bits(2, 8'hA1, 8, 1, 16'hA1A0);
      push_bits(2, 8'hA3, 8, 1, 16'hA3A2);
      play();
      idle(20);
      check("skew_skew_err", 32'(ke2), 32'h0);
      check("skew_pkt_start", n_ps2 - b_ps, 1);
      check("skew_pkt_end", n_pe2 - b_pe, 1);
      check("skew_drained", exp2.size(), 0);

      // Reset in the middle of DATA.
      preamble(1, 0);
      push_bits(1, 8'h33, 4, 0, 16'h0);
      preamble(2, 0);
      push_bits(2, 8'h44, 4, 0, 16'h0);
      play();
      @(posedge clk);
      #1;
      check("rst_pre_state", 32'(ls2), 32'({StData, StData}));
      @(negedge clk);
      rst = 1'b1;
      lp2 = {LP11, LP11};
      hs2 = '0;
      @(negedge clk);
      check_reset_outputs("midrst");
      rst = 1'b0;
      b_pe = n_pe2;
      idle(20);
      check("midrst_no_pkt_end", n_pe2 - b_pe, 0);

      // Clean burst after reset.
      b_ps = n_ps2; b_pe = n_pe2;
      preamble(1, 0);
      push_bits(1, 8'hE0, 8, 0, 16'h0);
      push_bits(1, 8'hE2, 8, 0, 16'h0);
      preamble(2, 0);
      push_bits(2, 8'hE1, 8, 1, 16'hE1E0);
      push_bits(2, 8'hE3, 8, 1, 16'hE3E2);
      play();
      idle(20);
      check("post_rst_pkt_start", n_ps2 - b_ps, 1);
      check("post_rst_pkt_end", n_pe2 - b_pe, 1);
      check("post_rst_drained", exp2.size(), 0);
      check("final_exp1_drained", exp1.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
